mips_muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It consumes the two operands read from the register file (rs on read port 1, rt on read port 2) and executes MULT, MULTU, DIV and DIVU over a fixed 33-cycle latency. It also serves MTHI/MTLO writes and exposes HI/LO continuously for MFHI/MFLO writeback.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/mips_muldiv_if.sv | 29 ++
 rtl/mips_muldiv_core.sv | 54 +++++
 rtl/mips_muldiv.sv | 141 ++++++++++++++
 tb/tb_mips_muldiv.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit.
// Holds the op encodings, the sequencer state set and the default operand width.
// Pure declarations; no logic, no latency, no flow control.
package mips_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

    // MULT and DIV work on two's-complement operands; the U variants do not.
    function automatic logic op_is_signed(input op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic op_is_div(input op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mips_muldiv_if.sv
// Request/result bundle between the datapath and the multiply/divide unit.
// master drives requests and MTHI/MTLO writes; slave returns HI/LO, busy and done.
// No flow control beyond busy: requests made while busy are ignored by the unit.
interface mips_muldiv_if
    import mips_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    op_t              op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mips_muldiv_core.sv
// Unsigned iterative engine: shift-add multiply or restoring shift-subtract divide.
// One bit per step; WIDTH steps after load give the product / {remainder, quotient}.
// No backpressure: steps only when told to, holds its accumulator otherwise.
module mips_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc
);
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_top;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;

    // Next accumulator value for one multiply step and one divide step.
    always_comb begin
        // Multiply: low half holds the remaining multiplier bits, high half the
        // partial product; add the multiplicand on a 1 bit and shift right.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        // Divide: shift {rem, dividend} left, trial-subtract the divisor from the
        // widened remainder and shift the quotient bit into the bottom.
        div_top  = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge   = (div_top >= {1'b0, b_q});
        div_sub  = div_top[WIDTH-1:0] - b_q;
        div_next = {(div_ge ? div_sub : div_top[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end

    // Accumulator and operand registers; both modes load the same layout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            b_q   <= '0;
        end else if (load) begin
            acc_q <= {{WIDTH{1'b0}}, a};
            b_q   <= b;
        end else if (step) begin
            acc_q <= div_mode ? div_next : mul_next;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mips_muldiv.sv
// MIPS HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Fixed latency: start at edge N, HI/LO written and done pulsed at edge N+33.
// busy blocks new requests and HI/LO writes; a start in the done cycle is accepted.
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    mips_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      cnt;
    op_t                op_q;
    logic               neg_a;
    logic               neg_b;
    logic               div0;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic               accept;
    logic               req_signed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign accept     = (state == IDLE) && bus.start;
    assign req_signed = op_is_signed(bus.op);
    assign mag_a      = (req_signed && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    assign mag_b      = (req_signed && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;

    mips_muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .step     (state == RUN),
        .div_mode (op_is_div(op_q)),
        .a        (mag_a),
        .b        (mag_b),
        .acc      (acc)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept in IDLE, WIDTH steps in RUN, one result cycle in FIX.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (cnt == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sign correction of the unsigned engine result, with the divide-by-zero override.
    always_comb begin
        prod = ((op_q == MULT) && (neg_a ^ neg_b)) ? -acc : acc;
        quo  = ((op_q == DIV) && (neg_a ^ neg_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = ((op_q == DIV) && neg_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (op_is_div(op_q)) begin
            fix_hi = div0 ? a_raw : rem;
            fix_lo = div0 ? '1    : quo;
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    // Request latch, step counter, HI/LO registers and the busy/done flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            op_q   <= MULT;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            div0   <= 1'b0;
            a_raw  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // A start in the same cycle as MTHI/MTLO drops the writes.
                        cnt    <= CW'(WIDTH - 1);
                        op_q   <= bus.op;
                        neg_a  <= req_signed && bus.rs_data[WIDTH-1];
                        neg_b  <= req_signed && bus.rt_data[WIDTH-1];
                        div0   <= (bus.rt_data == '0);
                        a_raw  <= bus.rs_data;
                        busy_q <= 1'b1;
                    end else begin
                        if (bus.hi_we) hi_q <= bus.rs_data;
                        if (bus.lo_we) lo_q <= bus.rs_data;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv: directed vector table, corner sequences and random ops.
// Every result is compared against a plain-arithmetic HI/LO model.
// Latency and busy width are measured on every operation.
module tb_mips_muldiv;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_muldiv_if #(.WIDTH(32)) mif ();

    mips_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] l;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: HI/LO straight from the architectural definition.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int     sa, sb, q, r;
        longint p;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            2'b01: return 64'(a) * 64'(b);
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Issue one op from a negedge; returns at the negedge where done is seen.
    // lat counts edges after the accepting edge; bcnt counts busy-high samples.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit noise, input bit mt,
                         output logic [31:0] h, output logic [31:0] l,
                         output int lat, output int bcnt);
        logic [31:0] old_hi;
        old_hi      = mif.hi;
        mif.start   = 1'b1;
        mif.op      = op_t'(op);
        mif.rs_data = a;
        mif.rt_data = b;
        mif.hi_we   = mt;
        mif.lo_we   = 1'b0;
        @(negedge clk);
        mif.start = 1'b0;
        mif.hi_we = 1'b0;
        if (mt) chk("start_beats_mthi", mif.hi, old_hi);
        lat  = 0;
        bcnt = 0;
        while (mif.done !== 1'b1 && lat < 100) begin
            if (mif.busy === 1'b1) bcnt++;
            if (noise) begin
                mif.start   = 1'($urandom_range(0, 1));
                mif.hi_we   = 1'($urandom_range(0, 1));
                mif.lo_we   = 1'($urandom_range(0, 1));
                mif.rs_data = 32'h1234;
                mif.rt_data = $urandom;
                mif.op      = op_t'($urandom_range(0, 3));
            end
            @(negedge clk);
            lat++;
        end
        mif.start = 1'b0;
        mif.hi_we = 1'b0;
        mif.lo_we = 1'b0;
        h = mif.hi;
        l = mif.lo;
    endtask

    initial begin
        logic [31:0] h, l, a, b;
        logic [63:0] exp;
        logic [1:0]  op;
        int          lat, bcnt, extra;

        tbl[0] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        tbl[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        tbl[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[5] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        tbl[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[7] = '{2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
        tbl[8] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
        tbl[9] = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};

        reset       = 1'b1;
        mif.start   = 1'b0;
        mif.op      = MULT;
        mif.rs_data = '0;
        mif.rt_data = '0;
        mif.hi_we   = 1'b0;
        mif.lo_we   = 1'b0;
        #12;
        chk("reset_hi", mif.hi, 32'h0);
        chk("reset_lo", mif.lo, 32'h0);
        chk("reset_busy", 32'(mif.busy), 32'h0);
        chk("reset_done", 32'(mif.done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // MTLO, MTHI, then both at once.
        mif.lo_we = 1'b1; mif.rs_data = 32'h0000_ABCD;
        @(negedge clk);
        mif.lo_we = 1'b0;
        chk("mtlo_lo", mif.lo, 32'h0000_ABCD);
        chk("mtlo_hi_untouched", mif.hi, 32'h0);
        mif.hi_we = 1'b1; mif.rs_data = 32'h0000_5A5A;
        @(negedge clk);
        mif.hi_we = 1'b0;
        chk("mthi_hi", mif.hi, 32'h0000_5A5A);
        mif.hi_we = 1'b1; mif.lo_we = 1'b1; mif.rs_data = 32'h0000_0077;
        @(negedge clk);
        mif.hi_we = 1'b0; mif.lo_we = 1'b0;
        chk("mtboth_hi", mif.hi, 32'h0000_0077);
        chk("mtboth_lo", mif.lo, 32'h0000_0077);

        // start with hi_we in the same cycle: the MTHI is dropped.
        do_op(2'b01, 32'h0000_0055, 32'h0000_0002, 1'b0, 1'b1, h, l, lat, bcnt);
        chk("start_mthi_hi", h, 32'h0);
        chk("start_mthi_lo", l, 32'h0000_00AA);

        // Directed table, issued back-to-back from each done cycle; odd rows
        // hammer start/hi_we/lo_we while busy.
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, (i % 2) == 1, 1'b0, h, l, lat, bcnt);
            chk($sformatf("tbl%0d_hi", i), h, tbl[i].h);
            chk($sformatf("tbl%0d_lo", i), l, tbl[i].l);
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd33);
            chk($sformatf("tbl%0d_busy_cycles", i), 32'(bcnt), 32'd33);
        end

        // No stray done after the noisy operations.
        @(negedge clk);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (mif.done === 1'b1) extra++;
            @(negedge clk);
        end
        chk("no_extra_done", 32'(extra), 32'd0);
        chk("idle_busy", 32'(mif.busy), 32'd0);

        // Random operations against the model.
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            exp = model(op, a, b);
            do_op(op, a, b, ($urandom_range(0, 3) == 0), 1'b0, h, l, lat, bcnt);
            chk($sformatf("rnd%0d_op%0d_%h_%h_hi", i, op, a, b), h, exp[63:32]);
            chk($sformatf("rnd%0d_op%0d_%h_%h_lo", i, op, a, b), l, exp[31:0]);
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd33);
        end

        // Reset about ten cycles into a DIVU; HI/LO are made nonzero first.
        @(negedge clk);
        mif.hi_we = 1'b1; mif.lo_we = 1'b1; mif.rs_data = 32'hDEAD_BEEF;
        @(negedge clk);
        mif.hi_we = 1'b0; mif.lo_we = 1'b0;
        mif.start = 1'b1; mif.op = DIVU; mif.rs_data = 32'd100; mif.rt_data = 32'd7;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrun_reset_hi", mif.hi, 32'h0);
        chk("midrun_reset_lo", mif.lo, 32'h0);
        chk("midrun_reset_busy", 32'(mif.busy), 32'h0);
        chk("midrun_reset_done", 32'(mif.done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_idle_busy", 32'(mif.busy), 32'h0);
        do_op(2'b01, 32'd3, 32'd5, 1'b0, 1'b0, h, l, lat, bcnt);
        chk("post_reset_hi", h, 32'h0);
        chk("post_reset_lo", l, 32'd15);
        chk("post_reset_latency", 32'(lat), 32'd33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
